// File: rtl/ob_scan_if.sv
// rtl/ob_scan_if.sv - observer-port and record-stream bundle for ob_scan
interface ob_scan_if;
  logic        start_i;
  logic        cont_i;
  logic [2:0]  ob_mode_o;
  logic [4:0]  ob_sel_o;
  logic [31:0] ob_data_i;
  logic        rec_valid_o;
  logic        rec_ready_i;
  logic [7:0]  rec_tag_o;
  logic [31:0] rec_data_o;
  logic        rec_last_o;
  logic        busy_o;
  logic [15:0] frame_cnt_o;

  modport master (
    input  start_i, cont_i, ob_data_i, rec_ready_i,
    output ob_mode_o, ob_sel_o, rec_valid_o, rec_tag_o, rec_data_o,
           rec_last_o, busy_o, frame_cnt_o
  );

  modport slave (
    output start_i, cont_i, ob_data_i, rec_ready_i,
    input  ob_mode_o, ob_sel_o, rec_valid_o, rec_tag_o, rec_data_o,
           rec_last_o, busy_o, frame_cnt_o
  );
endinterface

// File: rtl/ob_scan.sv
// rtl/ob_scan.sv - sweeps the CPU observer port and emits one tagged record per item
module ob_scan #(
  parameter int NUM_REGS = 32,
  parameter int SETTLE   = 1
) (
  input  logic      clk,
  input  logic      rst,
  ob_scan_if.master bus
);

  localparam logic [5:0] LAST_IDX   = 6'(NUM_REGS + 4);
  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  typedef enum logic [1:0] {IDLE, SEL, HOLD} state_t;

  state_t      state;
  logic [5:0]  item;
  logic [3:0]  settle_cnt;
  logic [2:0]  mode;
  logic [4:0]  sel;
  logic        valid;
  logic [7:0]  tag;
  logic [31:0] data;
  logic        last;
  logic        busy;
  logic [15:0] frame_cnt;

  // Items 0..4 are the fixed PC/IR/ALU views, everything after is a GPR.
  function automatic logic [2:0] item_mode(input logic [5:0] idx);
    return (idx < 6'd5) ? idx[2:0] : 3'd5;
  endfunction

  function automatic logic [4:0] item_sel(input logic [5:0] idx);
    return (idx < 6'd5) ? 5'd0 : 5'(idx - 6'd5);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      item       <= 6'd0;
      settle_cnt <= 4'd0;
      mode       <= 3'd0;
      sel        <= 5'd0;
      valid      <= 1'b0;
      tag        <= 8'd0;
      data       <= 32'd0;
      last       <= 1'b0;
      busy       <= 1'b0;
      frame_cnt  <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            item       <= 6'd0;
            mode       <= 3'd0;
            sel        <= 5'd0;
            settle_cnt <= 4'd0;
            busy       <= 1'b1;
            state      <= SEL;
          end
        end
        SEL: begin
          settle_cnt <= settle_cnt + 4'd1;
          if (settle_cnt + 4'd1 == SETTLE_CNT) begin
            data  <= bus.ob_data_i;
            tag   <= {mode, sel};
            valid <= 1'b1;
            last  <= (item == LAST_IDX);
            state <= HOLD;
          end
        end
        HOLD: begin
          // valid is always high here, so ready alone marks the transfer edge
          if (bus.rec_ready_i) begin
            valid      <= 1'b0;
            settle_cnt <= 4'd0;
            if (!last) begin
              item  <= item + 6'd1;
              mode  <= item_mode(item + 6'd1);
              sel   <= item_sel(item + 6'd1);
              state <= SEL;
            end else begin
              frame_cnt <= frame_cnt + 16'd1;
              item      <= 6'd0;
              mode      <= 3'd0;
              sel       <= 5'd0;
              if (bus.cont_i) begin
                state <= SEL;
              end else begin
                busy  <= 1'b0;
                state <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ob_mode_o   = mode;
  assign bus.ob_sel_o    = sel;
  assign bus.rec_valid_o = valid;
  assign bus.rec_tag_o   = tag;
  assign bus.rec_data_o  = data;
  assign bus.rec_last_o  = last;
  assign bus.busy_o      = busy;
  assign bus.frame_cnt_o = frame_cnt;

endmodule
